// File: rtl/fp_norm_share_ctrl_if.sv
// Request/result bundle for the shared mantissa normalizer.
// Slave side is the normalizer; master side drives requests and takes results.
interface fp_norm_share_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int EXP_W = 8,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*24-1:0]    req_mant;
    logic [NREQ*EXP_W-1:0] req_exp;
    logic                  out_valid;
    logic                  out_ready;
    logic [23:0]           out_mant;
    logic [EXP_W-1:0]      out_exp;
    logic [4:0]            out_shift;
    logic [ID_W-1:0]       out_id;
    logic                  out_zero;
    logic                  out_uflow;

    modport slave (
        input  req_valid, req_mant, req_exp, out_ready,
        output req_ready, out_valid, out_mant, out_exp,
        output out_shift, out_id, out_zero, out_uflow
    );

    modport master (
        output req_valid, req_mant, req_exp, out_ready,
        input  req_ready, out_valid, out_mant, out_exp,
        input  out_shift, out_id, out_zero, out_uflow
    );
endinterface

// File: rtl/fp_norm_share_ctrl.sv
// Round-robin shared 24-bit leading-zero normalizer with
// exponent adjust, underflow flush and a 2-stage valid/ready pipe.
module fp_norm_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int EXP_W = 8,
    parameter int ID_W  = 2
) (
    input logic clk,
    input logic rst,
    fp_norm_share_ctrl_if.slave bus
);

    logic             s1_valid;
    logic [23:0]      s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [ID_W-1:0]  s1_id;
    logic [ID_W-1:0]  ptr;

    logic             o_valid;
    logic [23:0]      o_mant;
    logic [EXP_W-1:0] o_exp;
    logic [4:0]       o_shift;
    logic [ID_W-1:0]  o_id;
    logic             o_zero;
    logic             o_uflow;

    logic             s1_adv;
    logic             s2_adv;
    logic             any;
    logic             hi_found;
    logic [ID_W-1:0]  hi;
    logic [ID_W-1:0]  lo;
    logic [ID_W-1:0]  gnt;
    logic             hs;

    assign s2_adv = bus.out_ready | ~o_valid;
    assign s1_adv = ~s1_valid | s2_adv;

    // lowest valid index at/above ptr wins; otherwise wrap to lowest overall
    always_comb begin
        any      = 1'b0;
        hi_found = 1'b0;
        hi       = '0;
        lo       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any = 1'b1;
                lo  = ID_W'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi       = ID_W'(i);
                end
            end
        end
        gnt = hi_found ? hi : lo;
    end

    assign hs            = any & s1_adv & ~rst;
    assign bus.req_ready = hs ? (NREQ'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_id    <= '0;
        end else begin
            if (hs) begin
                ptr     <= (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
                s1_mant <= bus.req_mant[24*gnt +: 24];
                s1_exp  <= bus.req_exp[EXP_W*gnt +: EXP_W];
                s1_id   <= gnt;
            end
            if (s1_adv) s1_valid <= hs;
        end
    end

    logic        z16, z8, z4, z2, z1;
    logic [23:0] m16, m8, m4, m2, m1;
    logic [4:0]  shift;
    logic        is_zero;
    logic        uflow;

    always_comb begin
        z16 = (s1_mant[23:8] == '0);
        m16 = z16 ? {s1_mant[7:0], 16'h0} : s1_mant;
        z8  = (m16[23:16] == '0);
        m8  = z8 ? {m16[15:0], 8'h0} : m16;
        z4  = (m8[23:20] == '0);
        m4  = z4 ? {m4_lo(m8), 4'h0} : m8;
        z2  = (m4[23:22] == '0);
        m2  = z2 ? {m4[21:0], 2'h0} : m4;
        z1  = ~m2[23];
        m1  = z1 ? {m2[22:0], 1'b0} : m2;
        shift   = {z16, z8, z4, z2, z1};
        is_zero = (s1_mant == '0);
        uflow   = ~is_zero & (32'(shift) > 32'(s1_exp));
    end

    function automatic logic [19:0] m4_lo(input logic [23:0] m);
        return m[19:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_mant  <= '0;
            o_exp   <= '0;
            o_shift <= '0;
            o_id    <= '0;
            o_zero  <= 1'b0;
            o_uflow <= 1'b0;
        end else if (s2_adv) begin
            o_valid <= s1_valid;
            o_id    <= s1_id;
            o_zero  <= is_zero;
            o_uflow <= uflow;
            if (is_zero) begin
                o_mant  <= '0;
                o_exp   <= '0;
                o_shift <= '0;
            end else if (uflow) begin
                o_mant  <= '0;
                o_exp   <= '0;
                o_shift <= shift;
            end else begin
                o_mant  <= m1;
                o_exp   <= s1_exp - EXP_W'(shift);
                o_shift <= shift;
            end
        end
    end

    assign bus.out_valid = o_valid;
    assign bus.out_mant  = o_mant;
    assign bus.out_exp   = o_exp;
    assign bus.out_shift = o_shift;
    assign bus.out_id    = o_id;
    assign bus.out_zero  = o_zero;
    assign bus.out_uflow = o_uflow;

endmodule

// File: doc/fp_norm_share_ctrl.md
Name: fp_norm_share_ctrl

Overview:
- Time-shares one 24-bit leading-zero normalize datapath among NREQ mantissa producers (adder/subtractor result paths) in the float pipeline.
- Arbitrates round-robin and normalizes the granted mantissa so its MSB is 1.
- Adjusts the exponent by the shift count and flushes underflow to zero.
- Returns the result with the requester ID through a 2-stage valid/ready pipeline.

Parameters:
NREQ, 4, number of requesters (2..8)
EXP_W, 8, exponent width
ID_W, 2, requester ID width; must equal clog2(NREQ)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_mant  in  NREQ*24  packed mantissas, requester i at [24i+23:24i]
req_exp  in  NREQ*EXP_W  packed unsigned biased exponents
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_mant  out  24  normalized mantissa
out_exp  out  EXP_W  adjusted exponent
out_shift  out  5  left-shift amount applied (0..23)
out_id  out  ID_W  requester index of this result
out_zero  out  1  input mantissa was zero
out_uflow  out  1  exponent underflow, result flushed

Behaviour:
- Reset (rst high at a clk edge):
  - Both stage valids clear; out_valid=0; req_ready=0.
  - out_mant, out_exp, out_shift, out_id, out_zero and out_uflow all 0.
  - RR pointer=0.
  - Reset mid-operation discards in-flight data with no output.
- Pipeline:
  - S1 register holds {mant, exp, id}. S2 (output) register holds the result.
  - s2_adv = out_ready | ~out_valid.
  - s1_adv = ~s1_valid | s2_adv.
- Arbitration (combinational, same cycle):
  - When s1_adv=1, grant the first asserted req_valid searching from index ptr upward, wrapping NREQ-1 to 0.
  - req_ready[g]=1 for the granted index only. Handshake = req_valid[g] & req_ready[g].
  - req_ready is 0 for all when s1_adv=0 or no request is asserted.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- RR pointer:
  - On a handshake, ptr <= (g+1) mod NREQ. Unchanged otherwise.
  - A requester holding valid is served within NREQ accepts.
- S1 load:
  - On handshake, S1 <= {req_mant[g], req_exp[g], g} and s1_valid <= 1.
  - If s1_adv with no handshake, s1_valid <= 0.
- S2 load (when s2_adv):
  - S2 takes the normalized S1 content; out_valid <= s1_valid.
  - Normalization is a combinational 5-level shifter (16/8/4/2/1) with shift = leading-zero count of mant.
  - mant_n = mant << shift, with MSB=1 for any nonzero mant.
  - If mant==0: out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_uflow=0.
  - Else if shift > exp (unsigned): out_uflow=1, out_mant=0, out_exp=0, out_shift=shift.
  - Else: out_exp = exp - shift (shift==exp gives 0 with no uflow), out_mant=mant_n, out_shift=shift.
  - out_id always carries the S1 id.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Latency: handshake at edge N gives out_valid at edge N+1 (registered S2 output). Sustains 1 result/cycle with out_ready=1.
- Simultaneous: S1 handshake and S2 consume in the same cycle are both taken (no bubble).
- Full: S1 and S2 both valid with out_ready=0 → req_ready all 0.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 → out_valid=0, req_ready=0, ptr=0. First grant after release is req 0.
- Normalize: req1 mant=24'h000F00, exp=8'd100, out_ready=1 → out_mant=24'hF00000, out_shift=12, out_exp=88, out_id=1, one cycle after the handshake.
- Zero/underflow:
  - mant=0 → out_zero=1, all other fields 0.
  - mant=24'h000001, exp=10 → shift=23, out_uflow=1, out_mant=0, out_exp=0.
  - mant=24'h000001, exp=23 → out_exp=0, out_uflow=0.
- Round-robin: all 4 req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each out_id matches the input.
- Backpressure: out_ready=0 for 5 cycles under continuous requests → exactly 2 accepts, then req_ready=0, out_* stable. Release → results drain in order, no loss or duplication.
- Mid-op reset: assert rst with S1 and S2 full → next cycle out_valid=0. Old results never appear.
